// File: rtl/chirp_if.sv
// Handshake and data bundle between the pulse controller, the chirp sequencer and the DDS.
// The master side drives chirp parameters and control; the slave side (the sequencer) answers.
interface chirp_if #(
  parameter int PHASE_W = 32
);
  logic [127:0]        chirp_parameters_in;
  logic                chirp_init;
  logic                chirp_enable;
  logic                chirp_ready;
  logic                chirp_active;
  logic                chirp_done;
  logic                chirp_abort;
  logic [PHASE_W-1:0]  dds_phase_tdata;
  logic                dds_phase_tvalid;
  logic [31:0]         sample_index;

  modport master (
    output chirp_parameters_in, chirp_init, chirp_enable,
    input  chirp_ready, chirp_active, chirp_done, chirp_abort,
    input  dds_phase_tdata, dds_phase_tvalid, sample_index
  );

  modport slave (
    input  chirp_parameters_in, chirp_init, chirp_enable,
    output chirp_ready, chirp_active, chirp_done, chirp_abort,
    output dds_phase_tdata, dds_phase_tvalid, sample_index
  );
endinterface

// File: rtl/chirp_sequencer.sv
// Linear-FM chirp generator: one phase word per clock, freq stepping by tuning_coef each sample.
// First word two cycles after chirp_init; no backpressure on the DDS stream, enable drop aborts.
module chirp_sequencer #(
  parameter int PHASE_W      = 32,
  parameter int GUARD_CYCLES = 4
) (
  input  logic   aclk,
  input  logic   areset,
  chirp_if.slave bus
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_INIT      = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_POST_DONE = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GUARD = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [GW-1:0]       guard_cnt;
  logic [PHASE_W-1:0]  freq_acc;
  logic [PHASE_W-1:0]  coef_sh;
  logic [31:0]         cmax_sh;

  logic                ready_q;
  logic                active_q;
  logic                done_q;
  logic                abort_q;
  logic [PHASE_W-1:0]  tdata_q;
  logic                tvalid_q;
  logic [31:0]         index_q;

  logic [31:0] freq_offset_f;
  logic [31:0] tuning_coef_f;
  logic [31:0] counter_max_f;
  logic [31:0] unused_bits;

  assign freq_offset_f = bus.chirp_parameters_in[95:64];
  assign tuning_coef_f = bus.chirp_parameters_in[63:32];
  assign counter_max_f = bus.chirp_parameters_in[31:0];
  assign unused_bits   = bus.chirp_parameters_in[127:96];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= S_GUARD;
      guard_cnt <= GUARD_INIT;
      freq_acc  <= '0;
      coef_sh   <= '0;
      cmax_sh   <= '0;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      index_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        S_GUARD: begin
          if (guard_cnt <= GW'(1)) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt - GW'(1);
          end
        end

        S_IDLE: begin
          if (bus.chirp_init && bus.chirp_enable) begin
            state    <= S_LOAD;
            ready_q  <= 1'b0;
            active_q <= 1'b1;
          end
        end

        S_LOAD: begin
          freq_acc <= PHASE_W'(freq_offset_f);
          coef_sh  <= PHASE_W'(tuning_coef_f);
          cmax_sh  <= counter_max_f;
          if (!bus.chirp_enable) begin
            state     <= S_GUARD;
            guard_cnt <= GUARD_INIT;
            active_q  <= 1'b0;
            abort_q   <= 1'b1;
          end else begin
            state    <= S_RUN;
            tvalid_q <= 1'b1;
            tdata_q  <= '0;
            index_q  <= '0;
          end
        end

        S_RUN: begin
          if (!bus.chirp_enable) begin
            state     <= S_GUARD;
            guard_cnt <= GUARD_INIT;
            active_q  <= 1'b0;
            abort_q   <= 1'b1;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            index_q   <= '0;
          end else if (index_q == cmax_sh) begin
            state    <= S_DONE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            index_q  <= '0;
          end else begin
            // tdata holds phase_n; advance to phase_{n+1} = phase_n + freq_n
            tdata_q  <= tdata_q + freq_acc;
            freq_acc <= freq_acc + coef_sh;
            index_q  <= index_q + 32'd1;
          end
        end

        S_DONE: begin
          // The DONE cycle itself counts as the first dead cycle
          if (GUARD_CYCLES <= 1) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            state     <= S_GUARD;
            guard_cnt <= GUARD_POST_DONE;
          end
        end

        default: begin
          state     <= S_GUARD;
          guard_cnt <= GUARD_INIT;
          ready_q   <= 1'b0;
          active_q  <= 1'b0;
          tvalid_q  <= 1'b0;
          tdata_q   <= '0;
          index_q   <= '0;
        end
      endcase
    end
  end

  assign bus.chirp_ready      = ready_q;
  assign bus.chirp_active     = active_q;
  assign bus.chirp_done       = done_q;
  assign bus.chirp_abort      = abort_q;
  assign bus.dds_phase_tdata  = tdata_q;
  assign bus.dds_phase_tvalid = tvalid_q;
  assign bus.sample_index     = index_q;

endmodule
